// File: rtl/game_click_port.sv
// game_click_port
//   Click interface for the minesweeper processor. A raw push-button is synchronised
//   and debounced. Each rising edge of the debounced level is one click. A click taken
//   while idle freezes the clamped cursor position and raises pressed. The click is held
//   until the processor clears it with pr_reset. Clicks that arrive while a click is
//   already held are dropped and counted in a saturating counter.
//
// Ports
//   clock_i        master clock, all state on the rising edge
//   reset_i        asynchronous, active-low reset
//   btn_raw_i      asynchronous push-button, 1 = held
//   cursor_x_i     live cursor x pixel (10 bits)
//   cursor_y_i     live cursor y pixel (9 bits)
//   pr_reset_i     processor clrp strobe: click consumed, clear pressed
//   nowCheck_i     processor nck strobe: click is being evaluated
//   pressed_o      1 = unconsumed click held
//   x_game_o       captured x, stable while pressed_o = 1
//   y_game_o       captured y, stable while pressed_o = 1
//   checking_o     1 = the processor is evaluating the held click
//   drop_count_o   saturating count of clicks lost while a click was held

module game_click_port #(
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int X_MAX           = 639,
  parameter int Y_MAX           = 479
) (
  input  logic       clock_i,
  input  logic       reset_i,
  input  logic       btn_raw_i,
  input  logic [9:0] cursor_x_i,
  input  logic [8:0] cursor_y_i,
  input  logic       pr_reset_i,
  input  logic       nowCheck_i,
  output logic       pressed_o,
  output logic [9:0] x_game_o,
  output logic [8:0] y_game_o,
  output logic       checking_o,
  output logic [7:0] drop_count_o
);

  localparam int              CW       = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0]   CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [9:0]      X_LIM    = 10'(X_MAX);
  localparam logic [8:0]      Y_LIM    = 9'(Y_MAX);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    HELD  = 2'd1,
    CHECK = 2'd2
  } state_e;

  logic          syncMeta_q, syncLvl_q;
  logic          debLvl_q, debLvl_d;
  logic          debPrev_q;
  logic [CW-1:0] cnt_q, cnt_d;
  state_e        state_q, state_d;
  logic [9:0]    xGame_q, xGame_d;
  logic [8:0]    yGame_q, yGame_d;
  logic [7:0]    dropCnt_q, dropCnt_d;
  logic          click;
  logic          accept;
  logic          drop;
  logic [9:0]    xClamp;
  logic [8:0]    yClamp;

  // Two-flop synchroniser plus debounced level and its one-cycle-delayed copy.
  always_ff @(posedge clock_i or negedge reset_i) begin
    if (!reset_i) begin
      syncMeta_q <= 1'b0;
      syncLvl_q  <= 1'b0;
      debLvl_q   <= 1'b0;
      debPrev_q  <= 1'b0;
      cnt_q      <= '0;
    end else begin
      syncMeta_q <= btn_raw_i;
      syncLvl_q  <= syncMeta_q;
      debLvl_q   <= debLvl_d;
      debPrev_q  <= debLvl_q;
      cnt_q      <= cnt_d;
    end
  end

  // The counter only runs while the synced level disagrees with the accepted level;
  // any bounce back to agreement restarts the stability window from zero.
  always_comb begin
    cnt_d    = cnt_q;
    debLvl_d = debLvl_q;
    if (syncLvl_q == debLvl_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_LAST) begin
      debLvl_d = ~debLvl_q;
      cnt_d    = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  assign click  = debLvl_q & ~debPrev_q;
  assign xClamp = (cursor_x_i > X_LIM) ? X_LIM : cursor_x_i;
  assign yClamp = (cursor_y_i > Y_LIM) ? Y_LIM : cursor_y_i;

  always_ff @(posedge clock_i or negedge reset_i) begin
    if (!reset_i) begin
      state_q   <= IDLE;
      xGame_q   <= '0;
      yGame_q   <= '0;
      dropCnt_q <= '0;
    end else begin
      state_q   <= state_d;
      xGame_q   <= xGame_d;
      yGame_q   <= yGame_d;
      dropCnt_q <= dropCnt_d;
    end
  end

  // A click colliding with pr_reset in HELD/CHECK is still a drop: the click edge
  // belonged to the old hold, so a fresh press is needed after returning to IDLE.
  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    drop    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (click) begin
          accept  = 1'b1;
          state_d = HELD;
        end
      end
      HELD: begin
        drop = click;
        if (pr_reset_i) begin
          state_d = IDLE;
        end else if (nowCheck_i) begin
          state_d = CHECK;
        end
      end
      CHECK: begin
        drop = click;
        if (pr_reset_i) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_comb begin
    xGame_d   = xGame_q;
    yGame_d   = yGame_q;
    dropCnt_d = dropCnt_q;
    if (accept) begin
      xGame_d = xClamp;
      yGame_d = yClamp;
    end
    if (drop && (dropCnt_q != 8'hFF)) begin
      dropCnt_d = dropCnt_q + 8'd1;
    end
  end

  assign pressed_o    = (state_q != IDLE);
  assign checking_o   = (state_q == CHECK);
  assign x_game_o     = xGame_q;
  assign y_game_o     = yGame_q;
  assign drop_count_o = dropCnt_q;

endmodule

// File: tb/tb_game_click_port.sv
// tb_game_click_port
//   Randomised scoreboard bench for game_click_port. Every clean press is turned by
//   the reference model into either an expected capture (pushed into a queue) or a
//   drop. A monitor pops the queue whenever pressed rises and compares coordinates.
//   Handshake state, drop counter and retained coordinates are compared after every
//   stimulus step.

module tb_game_click_port;

  localparam int D = 4;

  logic       clk;
  logic       rstN;
  logic       btn;
  logic [9:0] cursorX;
  logic [8:0] cursorY;
  logic       prReset;
  logic       nowCheck;
  logic       pressed;
  logic [9:0] xGame;
  logic [8:0] yGame;
  logic       checking;
  logic [7:0] dropCount;

  int checks = 0;
  int errors = 0;

  // reference model: abstract click-holder, no knowledge of debounce internals
  logic [18:0] expQ[$];
  bit          modelHeld;
  bit          modelChecking;
  int          modelDrops;
  int          modelX;
  int          modelY;
  bit          prevPressed;

  game_click_port #(
    .DEBOUNCE_CYCLES(D),
    .X_MAX(639),
    .Y_MAX(479)
  ) dut (
    .clock_i      (clk),
    .reset_i      (rstN),
    .btn_raw_i    (btn),
    .cursor_x_i   (cursorX),
    .cursor_y_i   (cursorY),
    .pr_reset_i   (prReset),
    .nowCheck_i   (nowCheck),
    .pressed_o    (pressed),
    .x_game_o     (xGame),
    .y_game_o     (yGame),
    .checking_o   (checking),
    .drop_count_o (dropCount)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int clampX(int v);
    return (v > 639) ? 639 : v;
  endfunction

  function automatic int clampY(int v);
    return (v > 479) ? 479 : v;
  endfunction

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%0d expected=%0d", name, actual, expected);
    end
  endtask

  // monitor: every new click presented by the DUT is matched against the scoreboard
  always @(negedge clk) begin
    logic [18:0] exp;
    if (rstN && pressed && !prevPressed) begin
      checks++;
      if (expQ.size() == 0) begin
        errors++;
        $display("[TB] FAIL capture unexpected click x=%0d y=%0d", xGame, yGame);
      end else begin
        exp = expQ.pop_front();
        if ({xGame, yGame} != exp) begin
          errors++;
          $display("[TB] FAIL capture actual=(%0d,%0d) expected=(%0d,%0d)",
                   xGame, yGame, exp[18:9], exp[8:0]);
        end
      end
    end
    prevPressed = pressed;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkState();
    @(negedge clk);
    checkOutput("pressed", int'(pressed), int'(modelHeld));
    checkOutput("checking", int'(checking), int'(modelChecking));
    checkOutput("drop_count", int'(dropCount), modelDrops);
    checkOutput("x_game", int'(xGame), modelX);
    checkOutput("y_game", int'(yGame), modelY);
  endtask

  task automatic modelClick(input int x, input int y);
    if (modelHeld) begin
      if (modelDrops < 255) modelDrops++;
    end else begin
      modelHeld = 1'b1;
      modelX    = clampX(x);
      modelY    = clampY(y);
      expQ.push_back({10'(modelX), 9'(modelY)});
    end
  endtask

  // clean press long enough to be accepted, then a clean release
  task automatic doPress(input int x, input int y);
    cursorX = 10'(x);
    cursorY = 9'(y);
    modelClick(x, y);
    btn = 1'b1;
    repeat (D + 5) tick();
    btn = 1'b0;
    cursorX = 10'($urandom_range(1023));
    cursorY = 9'($urandom_range(511));
    repeat (D + 5) tick();
  endtask

  task automatic pulse(input bit pr, input bit nc, input int len);
    prReset  = pr;
    nowCheck = nc;
    repeat (len) tick();
    prReset  = 1'b0;
    nowCheck = 1'b0;
    if (pr) begin
      modelHeld     = 1'b0;
      modelChecking = 1'b0;
    end else if (nc && modelHeld) begin
      modelChecking = 1'b1;
    end
    tick();
  endtask

  // press whose click edge lands in the same cycle as pr_reset and nowCheck
  task automatic collide();
    if (!modelHeld) begin
      doPress($urandom_range(1023), $urandom_range(511));
    end
    cursorX = 10'($urandom_range(1023));
    cursorY = 9'($urandom_range(511));
    btn = 1'b1;
    repeat (D + 2) tick();
    prReset  = 1'b1;
    nowCheck = 1'b1;
    tick();
    prReset  = 1'b0;
    nowCheck = 1'b0;
    if (modelDrops < 255) modelDrops++;
    modelHeld     = 1'b0;
    modelChecking = 1'b0;
    checkState();
    btn = 1'b0;
    repeat (D + 5) tick();
  endtask

  task automatic applyStimulus(input int kind);
    case (kind)
      0, 1:    doPress($urandom_range(1023), $urandom_range(511));
      2:       pulse(1'b1, 1'b0, $urandom_range(1, 3));
      3:       pulse(1'b0, 1'b1, $urandom_range(1, 3));
      4:       pulse(1'b1, 1'b1, $urandom_range(1, 2));
      default: collide();
    endcase
  endtask

  initial begin
    int n;
    btn      = 1'b1;
    cursorX  = 10'd50;
    cursorY  = 9'd60;
    prReset  = 1'b0;
    nowCheck = 1'b0;
    rstN     = 1'b1;
    modelHeld = 0; modelChecking = 0; modelDrops = 0; modelX = 0; modelY = 0;
    prevPressed = 1'b0;
    #2 rstN = 1'b0;

    // reset held with the button down: everything must stay cleared
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("reset_pressed", int'(pressed), 0);
    checkOutput("reset_checking", int'(checking), 0);
    checkOutput("reset_x", int'(xGame), 0);
    checkOutput("reset_y", int'(yGame), 0);
    checkOutput("reset_drop", int'(dropCount), 0);

    // release with the button still held: pressed must appear after D+3 clocks
    @(posedge clk);
    #1;
    modelClick(50, 60);
    rstN = 1'b1;
    n = 0;
    while (n < 50) begin
      @(posedge clk);
      n++;
      @(negedge clk);
      if (pressed) break;
    end
    checkOutput("press_latency", n, D + 3);
    btn = 1'b0;
    repeat (D + 5) tick();
    checkState();
    pulse(1'b1, 1'b0, 1);
    checkState();

    // capture with clamping, coordinates frozen afterwards
    doPress(700, 500);
    checkState();
    cursorX = 10'd3;
    cursorY = 9'd4;
    repeat (5) tick();
    checkState();
    pulse(1'b1, 1'b0, 1);
    checkState();

    // bouncing button never settles long enough to be accepted
    for (int i = 0; i < 20; i++) begin
      btn = ~btn;
      repeat (2) tick();
    end
    btn = 1'b0;
    repeat (D + 5) tick();
    checkState();

    // handshake: HELD -> CHECK -> IDLE, coordinates retained
    doPress(100, 200);
    checkState();
    pulse(1'b0, 1'b1, 1);
    checkState();
    pulse(1'b1, 1'b0, 1);
    checkState();

    // second click while held is dropped
    doPress(10, 10);
    doPress(20, 20);
    checkState();

    // collision of click edge, pr_reset and nowCheck
    collide();
    checkState();

    // randomised mix
    for (int i = 0; i < 40; i++) begin
      applyStimulus($urandom_range(5));
      checkState();
    end

    // saturation of the drop counter
    if (!modelHeld) doPress($urandom_range(1023), $urandom_range(511));
    for (int i = 0; i < 300; i++) begin
      doPress($urandom_range(1023), $urandom_range(511));
    end
    checkState();
    checkOutput("drop_saturated", int'(dropCount), 255);

    // reset in the middle of a held click discards it
    if (!modelHeld) doPress(5, 6);
    rstN = 1'b0;
    modelHeld = 0; modelChecking = 0; modelDrops = 0; modelX = 0; modelY = 0;
    expQ.delete();
    checkState();
    tick();
    rstN = 1'b1;
    repeat (3) tick();
    checkState();

    checkOutput("scoreboard_empty", expQ.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
